imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, writes little-endian
// 32-bit words into instruction memory, verifies an XOR checksum and releases
// the core from reset only after a complete, valid frame.
module imem_loader #(
    parameter int IMEM_WORDS = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // One extra bit so a 16-bit length can exceed the capacity in the compare.
    localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

    state_t      state;
    state_t      state_next;
    logic [15:0] frame_len;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] words_inc;

    assign accept     = in_valid && in_ready;
    assign len_full   = {in_data, frame_len[7:0]};
    assign words_inc  = 16'(words_loaded + 16'd1);
    assign imem_waddr = words_loaded[ADDR_W-1:0];
    assign imem_wdata = word;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_LO: begin
                if (accept) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_next = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CHECK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && byte_idx == 2'd3) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (words_inc == frame_len) begin
                    state_next = S_CHECK;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == csum) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_next = S_LEN_LO;
                end
            end
            default: state_next = S_LEN_LO;
        endcase
    end

    // Handshake and write-strobe outputs decoded from the current state
    always_comb begin
        in_ready = 1'b0;
        imem_we  = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: in_ready = 1'b1;
            S_WRITE:                             imem_we  = 1'b1;
            default: begin
                in_ready = 1'b0;
                imem_we  = 1'b0;
            end
        endcase
    end

    // Status flags are registered from the next state so they change on the
    // same edge the FSM enters or leaves DONE / ERROR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_reset_n <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            core_reset_n <= (state_next == S_DONE);
            load_done    <= (state_next == S_DONE);
            load_error   <= (state_next == S_ERROR);
        end
    end

    // Frame datapath: length capture, checksum, word assembly, word counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_len    <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            word         <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_LEN_LO: begin
                    if (accept) begin
                        frame_len[7:0] <= in_data;
                        csum           <= csum ^ in_data;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        frame_len[15:8] <= in_data;
                        csum            <= csum ^ in_data;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // Shift in from the top: after four bytes the first
                        // byte received sits in bits [7:0].
                        word     <= {in_data, word[31:8]};
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_inc;
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        frame_len    <= '0;
                        csum         <= '0;
                        byte_idx     <= '0;
                        words_loaded <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes and
// frame outcomes into a queue; a monitor pops and compares as they appear.
module tb_imem_loader;

    typedef logic [7:0] bytes_t[$];

    typedef struct {
        int unsigned kind;   // 0 = write, 1 = done, 2 = error
        logic [31:0] a;      // write address, or words_loaded for status
        logic [31:0] d;      // write data, or core_reset_n for status
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    exp_t        exp_q[$];
    logic        prev_done = 1'b0;
    logic        prev_error = 1'b0;

    imem_loader #(.IMEM_WORDS(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = 0; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_status(input int unsigned kind, input logic [31:0] wl, input logic [31:0] crn);
        exp_t e;
        e.kind = kind; e.a = wl; e.d = crn;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or finishes a frame
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (imem_we === 1'b1) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("write_kind", 32'(0), 32'(e.kind));
                    check("write_addr", 32'(imem_waddr), e.a);
                    check("write_data", imem_wdata, e.d);
                end
            end
            if ((load_done === 1'b1 && prev_done !== 1'b1) ||
                (load_error === 1'b1 && prev_error !== 1'b1)) begin
                check("status_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("status_kind", load_done ? 32'd1 : 32'd2, 32'(e.kind));
                    check("status_words", 32'(words_loaded), e.a);
                    check("status_core_reset_n", 32'(core_reset_n), e.d);
                end
            end
        end
        prev_done  <= load_done;
        prev_error <= load_error;
    end

    // Caller is at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input bytes_t b, input bit gaps);
        foreach (b[i]) begin
            send_byte(b[i]);
            if (gaps) @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_error"}, 32'(load_error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        bytes_t good, bad_ck, partial;
        good    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
        bad_ck  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC4};
        partial = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};

        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Two-word program with good checksum
        push_write(32'd0, 32'h00500093);
        push_write(32'd1, 32'h00100113);
        push_status(1, 32'd2, 32'd1);
        send_frame(good, 1'b0);
        drain("good_drain");
        check("good_in_ready", 32'(in_ready), 32'd0);
        check("good_core_reset_n", 32'(core_reset_n), 32'd1);
        do_restart();

        // Empty frame
        push_status(1, 32'd0, 32'd1);
        send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
        drain("empty_drain");
        do_restart();

        // Length 257 exceeds capacity
        push_status(2, 32'd0, 32'd0);
        send_frame('{8'h01, 8'h01}, 1'b0);
        drain("oversize_drain");
        check("oversize_in_ready", 32'(in_ready), 32'd0);
        check("oversize_core_reset_n", 32'(core_reset_n), 32'd0);
        do_restart();

        // Bad checksum after two writes
        push_write(32'd0, 32'h00500093);
        push_write(32'd1, 32'h00100113);
        push_status(2, 32'd2, 32'd0);
        send_frame(bad_ck, 1'b0);
        drain("badck_drain");
        check("badck_core_reset_n", 32'(core_reset_n), 32'd0);
        check("badck_error", 32'(load_error), 32'd1);
        do_restart();

        // Reset in the middle of a frame, then a full reload from address 0
        push_write(32'd0, 32'h00500093);
        send_frame(partial, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_reset_values("midrst");
        check("midrst_drain", 32'(exp_q.size()), 32'd0);
        push_write(32'd0, 32'h00500093);
        push_write(32'd1, 32'h00100113);
        push_status(1, 32'd2, 32'd1);
        send_frame(good, 1'b0);
        drain("reload_drain");
        do_restart();

        // Gapped valid, with a restart pulse mid-frame that must be ignored
        push_write(32'd0, 32'h00500093);
        push_write(32'd1, 32'h00100113);
        push_status(1, 32'd2, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send_byte(good[i]);
            @(negedge clk);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        for (int i = 3; i < 11; i++) begin
            send_byte(good[i]);
            @(negedge clk);
        end
        drain("gap_drain");
        check("gap_core_reset_n", 32'(core_reset_n), 32'd1);
        do_restart();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
